// File: rtl/rt_ex_wb_latch.sv
// EX->WB pipeline register: single-entry valid/ready stage, NZCV status register
// committed at retire, forwarding tap and saturating stall counter. Optional: RT_EX_STICKY_Q_EN.
module rt_ex_wb_latch #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_negative,
   input  logic              alu_overflow,
   input  logic              alu_carry,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_wr_en,
   input  logic              in_set_flags,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_wr_en,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_rd,
   output logic [DATA_W-1:0] fwd_data,
   output logic [3:0]        flags,
   input  logic              flags_we,
   input  logic [3:0]        flags_wdata,
   output logic              q_flag,
   input  logic              q_clr,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_next;

   logic [DATA_W-1:0]  r_result;
   logic [REG_AW-1:0]  r_rd;
   logic               r_wr_en;
   logic               r_set_flags;
   logic [3:0]         r_nzcv;
   logic [3:0]         r_flags;
   logic [CNT_W-1:0]   r_stall_cnt;

   logic               w_capture;
   logic               w_retire;
   logic               w_commit;
   logic               w_stall;

   assign out_valid = (r_state == ST_FULL);
   assign in_ready  = ~out_valid | out_ready;
   assign w_capture = in_valid & in_ready & ~flush;
   assign w_retire  = out_valid & out_ready;
   // A retire that coincides with flush is discarded, not committed.
   assign w_commit  = w_retire & ~flush;
   assign w_stall   = out_valid & ~out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_EMPTY: begin
            if (w_capture) begin
               w_state_next = ST_FULL;
            end
         end
         ST_FULL: begin
            if (flush) begin
               w_state_next = ST_EMPTY;
            end else if (w_retire && !w_capture) begin
               w_state_next = ST_EMPTY;
            end
         end
         default: w_state_next = ST_EMPTY;
      endcase
   end

   // Payload; rd==0 never writes, so the enable is cleared at capture time.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result    <= '0;
         r_rd        <= '0;
         r_wr_en     <= 1'b0;
         r_set_flags <= 1'b0;
         r_nzcv      <= 4'b0000;
      end else if (w_capture) begin
         r_result    <= alu_result;
         r_rd        <= in_rd;
         r_wr_en     <= in_wr_en & (in_rd != '0);
         r_set_flags <= in_set_flags;
         r_nzcv      <= {alu_negative, alu_zero, alu_carry, alu_overflow};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_flags <= 4'b0000;
      end else if (flags_we) begin
         r_flags <= flags_wdata;
      end else if (w_commit && r_set_flags) begin
         r_flags <= r_nzcv;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

`ifdef RT_EX_STICKY_Q_EN
   logic r_q_flag;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q_flag <= 1'b0;
      end else if (w_commit && r_nzcv[0]) begin
         r_q_flag <= 1'b1;
      end else if (q_clr) begin
         r_q_flag <= 1'b0;
      end
   end

   assign q_flag = r_q_flag;
`else
   logic w_unused_q_clr;

   assign w_unused_q_clr = q_clr;
   assign q_flag         = 1'b0;
`endif

   assign out_result = r_result;
   assign out_rd     = r_rd;
   assign out_wr_en  = r_wr_en;
   assign fwd_valid  = out_valid & r_wr_en;
   assign fwd_rd     = r_rd;
   assign fwd_data   = r_result;
   assign flags      = r_flags;
   assign stall_cnt  = r_stall_cnt;

endmodule
